// File: rtl/timer0_prescaler.sv
// Timer0 clock-source selection: 10-bit system-clock prescaler, synchronised
// T0 pin edge detection, TCNT0 increment value and overflow flag.
module timer0_prescaler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic [2:0] cs,
  input  logic       t0_pin,
  input  logic       psr_clear,
  input  logic [7:0] tcnt_current,
  input  logic       tov_clear,
  output logic       count_enable,
  output logic [7:0] tcnt_next,
  output logic       tov0
);

  logic [9:0]             presc;
  logic [SYNC_STAGES-1:0] t0_sync;
  logic                   t0_hist;
  logic                   t0_rise;
  logic                   t0_fall;
  logic                   overflow;

  // Prescaler: cleared by psr_clear, frozen while the timer is stopped.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      presc <= 10'd0;
    end else if (psr_clear) begin
      presc <= 10'd0;
    end else if (cs != 3'd0) begin
      presc <= presc + 10'd1;
    end
  end

  // Synchroniser and history run regardless of cs so a later switch to an
  // external source never sees a stale edge.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      t0_sync <= '0;
      t0_hist <= 1'b0;
    end else begin
      t0_sync <= {t0_sync[SYNC_STAGES-2:0], t0_pin};
      t0_hist <= t0_sync[SYNC_STAGES-1];
    end
  end

  assign t0_rise =  t0_sync[SYNC_STAGES-1] & ~t0_hist;
  assign t0_fall = ~t0_sync[SYNC_STAGES-1] &  t0_hist;

  always_comb begin
    count_enable = 1'b0;
    if (!reset) begin
      case (cs)
        3'd1:    count_enable = 1'b1;
        3'd2:    count_enable = (presc[2:0] == 3'h7);
        3'd3:    count_enable = (presc[5:0] == 6'h3F);
        3'd4:    count_enable = (presc[7:0] == 8'hFF);
        3'd5:    count_enable = (presc == 10'h3FF);
        3'd6:    count_enable = t0_fall;
        3'd7:    count_enable = t0_rise;
        default: count_enable = 1'b0;
      endcase
    end
  end

  assign tcnt_next = tcnt_current + 8'd1;
  assign overflow  = count_enable && (tcnt_current == 8'hFF);

  // Overflow set has priority over the software clear.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      tov0 <= 1'b0;
    end else if (overflow) begin
      tov0 <= 1'b1;
    end else if (tov_clear) begin
      tov0 <= 1'b0;
    end
  end

endmodule
